// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
// Latency: n/a (declarations only). Backpressure: n/a.
package period_meter_pkg;

    localparam int unsigned BASE_CLK_HZ = 50_000_000;
    localparam int unsigned PERIOD_W    = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

    typedef logic [PERIOD_W-1:0] period_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input plus a one-cycle rising-edge pulse.
// Latency: rise_o asserts 2-3 clk after the input rises. Backpressure: none.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign rise_o = sync_q & ~dly_q;

endmodule

// File: rtl/period_meter.sv
// Measures sig_in rise-to-rise period in clk cycles, rejects glitches, flags loss of signal.
// Latency: period/period_valid one clk after the detected rise (PERIOD_AVG_EN: averaged). Backpressure: none.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MIN_PERIOD = 1000,
    parameter int unsigned MAX_PERIOD = BASE_CLK_HZ,
    parameter int unsigned AVG_LOG2   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             no_signal,
    output logic             glitch
);

    localparam longint unsigned CNT_LIMIT = (64'd1 << WIDTH) - 64'd1;
    localparam logic [WIDTH-1:0] MIN_C    = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_PERIOD);

    if (MIN_PERIOD < 2 || MAX_PERIOD < MIN_PERIOD ||
        64'(MAX_PERIOD) >= CNT_LIMIT || AVG_LOG2 > 16) begin : g_bad_cfg
        $error("period_meter: illegal MIN_PERIOD/MAX_PERIOD/WIDTH/AVG_LOG2 combination");
    end

    logic rise;

    sync_edge_detect u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (sig_in),
        .rise_o  (rise)
    );

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q,  valid_d;
    logic             nosig_q,  nosig_d;
    logic             glitch_q, glitch_d;
    logic             accept;
    logic             tmo;

`ifdef PERIOD_AVG_EN
    localparam int unsigned ACC_W = WIDTH + AVG_LOG2;
    localparam int unsigned SW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SW-1:0] SAMP_LAST = SW'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum;
    logic [SW-1:0]    samp_q, samp_d;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        valid_d  = 1'b0;
        nosig_d  = nosig_q;
        glitch_d = 1'b0;
        accept   = 1'b0;
        tmo      = 1'b0;
`ifdef PERIOD_AVG_EN
        acc_d    = acc_q;
        samp_d   = samp_q;
        sum      = acc_q + ACC_W'(count_q);
`endif

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ARMED;
                    count_d = WIDTH'(1);
                end
            end
            ARMED: begin
                count_d = count_q + WIDTH'(1);
                // A rise on the MAX_PERIOD cycle wins over the timeout.
                if (rise) begin
                    if (count_q >= MIN_C) begin
                        accept  = 1'b1;
                        nosig_d = 1'b0;
                        count_d = WIDTH'(1);
                    end else begin
                        glitch_d = 1'b1;
                    end
                end else if (count_q == MAX_C) begin
                    tmo      = 1'b1;
                    state_d  = IDLE;
                    nosig_d  = 1'b1;
                    period_d = '0;
                    count_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PERIOD_AVG_EN
        if (tmo) begin
            acc_d  = '0;
            samp_d = '0;
        end else if (accept) begin
            if (samp_q == SAMP_LAST) begin
                period_d = WIDTH'(sum >> AVG_LOG2);
                valid_d  = 1'b1;
                acc_d    = '0;
                samp_d   = '0;
            end else begin
                acc_d  = sum;
                samp_d = samp_q + SW'(1);
            end
        end
`else
        if (accept) begin
            period_d = count_q;
            valid_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            nosig_q  <= 1'b1;
            glitch_q <= 1'b0;
`ifdef PERIOD_AVG_EN
            acc_q    <= '0;
            samp_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            nosig_q  <= nosig_d;
            glitch_q <= glitch_d;
`ifdef PERIOD_AVG_EN
            acc_q    <= acc_d;
            samp_q   <= samp_d;
`endif
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign no_signal    = nosig_q;
    assign glitch       = glitch_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: table of square-wave segments, scoreboard of expected events.
// Each segment begins with a rise of sig_in; its record states what that rise must produce.
module tb_period_meter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         sig_in;
    logic [W-1:0] period;
    logic         period_valid;
    logic         no_signal;
    logic         glitch;

    always #5 clk = ~clk;

    period_meter #(
        .WIDTH      (W),
        .MIN_PERIOD (10),
        .MAX_PERIOD (1000),
        .AVG_LOG2   (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sig_in       (sig_in),
        .period       (period),
        .period_valid (period_valid),
        .no_signal    (no_signal),
        .glitch       (glitch)
    );

    typedef enum int { K_NONE, K_ACC, K_GLT } kind_e;

    typedef struct {
        int    len;
        int    hi;
        kind_e kind;
        int    val;
        bit    ns;
    } seg_t;

    typedef struct {
        bit is_glt;
        int val;
    } ev_t;

    ev_t  sbq[$];
    seg_t tbl[19];
    int   total = 0;
    int   bad   = 0;
    int   acc_m = 0;
    int   n_m   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic note_rise(input kind_e k, input int v);
        ev_t e;
        case (k)
            K_NONE: begin
                acc_m = 0;
                n_m   = 0;
            end
            K_GLT: begin
                e.is_glt = 1'b1;
                e.val    = 0;
                sbq.push_back(e);
            end
            default: begin
`ifdef PERIOD_AVG_EN
                acc_m += v;
                n_m++;
                if (n_m == 4) begin
                    e.is_glt = 1'b0;
                    e.val    = acc_m >> 2;
                    sbq.push_back(e);
                    acc_m = 0;
                    n_m   = 0;
                end
`else
                e.is_glt = 1'b0;
                e.val    = v;
                sbq.push_back(e);
`endif
            end
        endcase
    endtask

    task automatic run_seg(input int idx, input seg_t sg);
        int chk_at;
        chk_at = (sg.len > 7) ? 6 : sg.len - 1;
        for (int i = 0; i < sg.len; i++) begin
            @(posedge clk);
            #1;
            sig_in = (i < sg.hi);
            if (i == 0) note_rise(sg.kind, sg.val);
            if (i == chk_at) begin
                @(negedge clk);
                check($sformatf("seg%0d_no_signal", idx), 32'(no_signal), 32'(sg.ns));
                if (sg.ns) check($sformatf("seg%0d_period_zero", idx), period, 32'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!reset && (period_valid || glitch)) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event valid=%0b glitch=%0b period=%0d",
                         period_valid, glitch, period);
            end else begin
                e = sbq.pop_front();
                if (glitch !== e.is_glt || period_valid === e.is_glt ||
                    (!e.is_glt && period !== W'(e.val))) begin
                    bad++;
                    $display("FAIL event got valid=%0b glitch=%0b period=%0d want glitch=%0b period=%0d",
                             period_valid, glitch, period, e.is_glt, e.val);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{100,  50, K_NONE,    0, 1'b1};
        tbl[1]  = '{100,  50, K_ACC,   100, 1'b0};
        tbl[2]  = '{100,  50, K_ACC,   100, 1'b0};
        tbl[3]  = '{100,  50, K_ACC,   100, 1'b0};
        tbl[4]  = '{5,     3, K_ACC,   100, 1'b0};
        tbl[5]  = '{95,    2, K_GLT,     0, 1'b0};
        tbl[6]  = '{100,  50, K_ACC,   100, 1'b0};
        tbl[7]  = '{1100, 50, K_ACC,   100, 1'b0};
        tbl[8]  = '{100,  50, K_NONE,    0, 1'b1};
        tbl[9]  = '{100,  50, K_ACC,   100, 1'b0};
        tbl[10] = '{10,    5, K_ACC,   100, 1'b0};
        tbl[11] = '{9,     4, K_ACC,    10, 1'b0};
        tbl[12] = '{991,   5, K_GLT,     0, 1'b0};
        tbl[13] = '{1001,  5, K_ACC,  1000, 1'b0};
        tbl[14] = '{100,  50, K_NONE,    0, 1'b1};
        tbl[15] = '{102,  50, K_ACC,   100, 1'b0};
        tbl[16] = '{98,   49, K_ACC,   102, 1'b0};
        tbl[17] = '{101,  50, K_ACC,    98, 1'b0};
        tbl[18] = '{100,  50, K_ACC,   101, 1'b0};

        reset  = 1'b1;
        sig_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            sig_in = i[0];
            @(negedge clk);
            check($sformatf("reset_cyc%0d", i),
                  {period[27:0], period_valid, no_signal, glitch, 1'b0},
                  {28'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        check("reset_period_hi", {28'd0, period[31:28]}, 32'd0);
        @(posedge clk);
        #1;
        sig_in = 1'b0;
        reset  = 1'b0;
        repeat (5) @(posedge clk);

        for (int s = 0; s < 19; s++) run_seg(s, tbl[s]);

        @(posedge clk);
        #1;
        sig_in = 1'b0;
        repeat (10) @(negedge clk);
        check("drain_after_table", sbq.size(), 32'd0);

        // Reset while armed and counting.
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        acc_m = 0;
        n_m   = 0;
        @(negedge clk);
        check("midreset_period", period, 32'd0);
        check("midreset_no_signal", 32'(no_signal), 32'd1);

        run_seg(100, '{100, 50, K_NONE, 0, 1'b1});
        run_seg(101, '{40,  20, K_ACC, 100, 1'b0});
        repeat (10) @(negedge clk);
        check("drain_final", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
